// File: rtl/seg7_rx_monitor_if.sv
// Display-path bus between a 7-segment source and the receive-side monitor.
// The master drives the segment lines; the slave (monitor) reports decoded events.
interface seg7_rx_monitor_if #(
    parameter int PERIOD_W = 24
);
    logic [6:0]          segments_in;
    logic [3:0]          digit;
    logic                digit_valid;
    logic [PERIOD_W-1:0] period;
    logic                period_valid;
    logic                seq_error;
    logic                invalid_pattern;
    logic                locked;
    logic [7:0]          error_count;

    modport master (
        output segments_in,
        input  digit,
        input  digit_valid,
        input  period,
        input  period_valid,
        input  seq_error,
        input  invalid_pattern,
        input  locked,
        input  error_count
    );

    modport slave (
        input  segments_in,
        output digit,
        output digit_valid,
        output period,
        output period_valid,
        output seq_error,
        output invalid_pattern,
        output locked,
        output error_count
    );
endinterface

// File: rtl/seg7_rx_monitor.sv
// Debounces a 7-segment bus, decodes it back to a hex digit, checks that digits
// count up modulo MODULUS and measures the cycle period between digit changes.
module seg7_rx_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int MODULUS       = 10,
    parameter int PERIOD_W      = 24
) (
    input  logic              clk,
    input  logic              reset,
    seg7_rx_monitor_if.slave  bus
);

    localparam int                  CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [4:0]          MOD_L   = 5'(MODULUS);
    localparam logic [PERIOD_W-1:0] PER_MAX = '1;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'h0: code = 7'b0111111;
            4'h1: code = 7'b0000110;
            4'h2: code = 7'b1011011;
            4'h3: code = 7'b1001111;
            4'h4: code = 7'b1100110;
            4'h5: code = 7'b1101101;
            4'h6: code = 7'b1111101;
            4'h7: code = 7'b0000111;
            4'h8: code = 7'b1111111;
            4'h9: code = 7'b1101111;
            4'hA: code = 7'b1110111;
            4'hB: code = 7'b1111100;
            4'hC: code = 7'b0111001;
            4'hD: code = 7'b1011110;
            4'hE: code = 7'b1111001;
            default: code = 7'b1110001;
        endcase
        return code;
    endfunction

    // Debounce and acceptance registers
    logic [6:0]          r_in;
    logic [6:0]          r_cand;
    logic [6:0]          r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [PERIOD_W-1:0] r_pcnt;

    // FSM and registered outputs
    state_t              r_state;
    logic [3:0]          r_digit;
    logic                r_digit_valid;
    logic [PERIOD_W-1:0] r_period;
    logic                r_period_valid;
    logic                r_seq_error;
    logic                r_invalid_pattern;
    logic                r_locked;
    logic [7:0]          r_error_count;

    logic [15:0]         w_hit;
    logic                w_code_valid;
    logic [3:0]          w_dec;
    logic                w_accept;
    logic [3:0]          w_expected_next;
    logic                w_seq_bad;
    logic [PERIOD_W-1:0] w_pcnt_inc;
    logic [7:0]          w_err_inc;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_decode
            assign w_hit[gi] = (r_cand == seg_code(4'(gi)));
        end
    endgenerate

    // Table codes are unique, so at most one hit is set.
    always_comb begin
        w_dec = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_hit[i]) begin
                w_dec = 4'(i);
            end
        end
    end

    assign w_code_valid = |w_hit;

    // The count reaching CNT_MAX means the candidate matched on STABLE_CYCLES samples.
    assign w_accept = (r_cnt == CNT_MAX) && (r_cand != r_acc);

    assign w_expected_next = ({1'b0, r_digit} == (MOD_L - 5'd1)) ? 4'd0 : (r_digit + 4'd1);

    // Out-of-range digits on either side can never form a legal increment.
    assign w_seq_bad = ({1'b0, w_dec} >= MOD_L) ||
                       ({1'b0, r_digit} >= MOD_L) ||
                       (w_dec != w_expected_next);

    assign w_pcnt_inc = (r_pcnt == PER_MAX) ? r_pcnt : (r_pcnt + PERIOD_W'(1));
    assign w_err_inc  = (r_error_count == 8'hFF) ? r_error_count : (r_error_count + 8'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in   <= 7'b0000000;
            r_cand <= 7'b0000000;
            r_cnt  <= '0;
        end else begin
            r_in <= bus.segments_in;
            if (r_in != r_cand) begin
                r_cand <= r_in;
                r_cnt  <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= ST_UNLOCKED;
            r_acc             <= 7'b0000000;
            r_pcnt            <= '0;
            r_digit           <= 4'd0;
            r_digit_valid     <= 1'b0;
            r_period          <= '0;
            r_period_valid    <= 1'b0;
            r_seq_error       <= 1'b0;
            r_invalid_pattern <= 1'b0;
            r_locked          <= 1'b0;
            r_error_count     <= 8'd0;
        end else begin
            r_digit_valid     <= 1'b0;
            r_period_valid    <= 1'b0;
            r_seq_error       <= 1'b0;
            r_invalid_pattern <= 1'b0;
            r_pcnt            <= w_pcnt_inc;

            if (w_accept) begin
                r_acc <= r_cand;
                if (w_code_valid) begin
                    r_digit       <= w_dec;
                    r_digit_valid <= 1'b1;
                    r_pcnt        <= '0;
                    if (r_state == ST_LOCKED) begin
                        r_period       <= w_pcnt_inc;
                        r_period_valid <= 1'b1;
                        if (w_seq_bad) begin
                            r_seq_error   <= 1'b1;
                            r_error_count <= w_err_inc;
                        end
                    end else begin
                        r_state  <= ST_LOCKED;
                        r_locked <= 1'b1;
                    end
                end else begin
                    r_invalid_pattern <= 1'b1;
                    r_error_count     <= w_err_inc;
                    r_state           <= ST_UNLOCKED;
                    r_locked          <= 1'b0;
                end
            end
        end
    end

    assign bus.digit           = r_digit;
    assign bus.digit_valid     = r_digit_valid;
    assign bus.period          = r_period;
    assign bus.period_valid    = r_period_valid;
    assign bus.seq_error       = r_seq_error;
    assign bus.invalid_pattern = r_invalid_pattern;
    assign bus.locked          = r_locked;
    assign bus.error_count     = r_error_count;

endmodule

// File: tb/tb_seg7_rx_monitor.sv
// Scoreboard bench for seg7_rx_monitor: a 24-bit-period and an 8-bit-period
// instance see the same segment stream; expected events are queued at drive time.
module tb_seg7_rx_monitor;
    localparam int S   = 4;
    localparam int MOD = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg7_rx_monitor_if #(.PERIOD_W(24)) bus ();
    seg7_rx_monitor_if #(.PERIOD_W(8))  bus8 ();

    seg7_rx_monitor #(.STABLE_CYCLES(S), .MODULUS(MOD), .PERIOD_W(24)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    seg7_rx_monitor #(.STABLE_CYCLES(S), .MODULUS(MOD), .PERIOD_W(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    typedef struct {
        int         cyc;
        logic [3:0] digit;
        logic       inv;
        logic       seq;
        logic       pv;
        int         per;
        logic       locked;
        logic [7:0] errs;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0] m_acc    = 7'b0000000;
    logic       m_locked = 1'b0;
    int         m_digit  = 0;
    int         m_errs   = 0;
    int         m_last   = 0;

    function automatic logic [6:0] seg(input int d);
        logic [6:0] c;
        case (d)
            0: c = 7'b0111111;  1: c = 7'b0000110;  2: c = 7'b1011011;  3: c = 7'b1001111;
            4: c = 7'b1100110;  5: c = 7'b1101101;  6: c = 7'b1111101;  7: c = 7'b0000111;
            8: c = 7'b1111111;  9: c = 7'b1101111;  10: c = 7'b1110111; 11: c = 7'b1111100;
            12: c = 7'b0111001; 13: c = 7'b1011110; 14: c = 7'b1111001; default: c = 7'b1110001;
        endcase
        return c;
    endfunction

    function automatic int dec(input logic [6:0] p);
        for (int i = 0; i < 16; i++) begin
            if (seg(i) == p) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_digit"},  {28'd0, bus.digit}, 32'd0);
        chk({tag, "_pulses"}, {28'd0, bus.digit_valid, bus.period_valid, bus.seq_error, bus.invalid_pattern}, 32'd0);
        chk({tag, "_period"}, {8'd0, bus.period}, 32'd0);
        chk({tag, "_locked"}, {31'd0, bus.locked}, 32'd0);
        chk({tag, "_errcnt"}, {24'd0, bus.error_count}, 32'd0);
        chk({tag, "_d8_any"}, {bus8.digit, bus8.digit_valid, bus8.period, bus8.period_valid,
                               bus8.seq_error, bus8.invalid_pattern, bus8.locked, bus8.error_count}, 32'd0);
    endtask

    // Drive pattern p for 'hold' cycles; queue the event it must produce, if any.
    task automatic apply(input logic [6:0] p, input int hold);
        int   d;
        exp_t e;
        @(negedge clk);
        bus.segments_in  = p;
        bus8.segments_in = p;
        if (hold >= S && p != m_acc) begin
            e.cyc = cyc + S + 2;
            e.inv = 1'b0; e.seq = 1'b0; e.pv = 1'b0; e.per = 0;
            d     = dec(p);
            m_acc = p;
            if (d < 0) begin
                e.inv    = 1'b1;
                e.digit  = 4'(m_digit);
                m_locked = 1'b0;
            end else begin
                e.digit = 4'(d);
                if (m_locked) begin
                    e.pv  = 1'b1;
                    e.per = e.cyc - m_last;
                    e.seq = (d >= MOD) || (m_digit >= MOD) || (d != (m_digit + 1) % MOD);
                end
                m_locked = 1'b1;
                m_digit  = d;
                m_last   = e.cyc;
            end
            if ((e.inv || e.seq) && m_errs != 255) m_errs++;
            e.locked = m_locked;
            e.errs   = 8'(m_errs);
            sb.push_back(e);
        end
        repeat (hold - 1) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && (bus.digit_valid || bus.invalid_pattern || bus.seq_error || bus.period_valid)) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", sb.size(), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("ev_cycle",   cyc, e.cyc);
                chk("ev_dvalid",  {31'd0, bus.digit_valid}, {31'd0, ~e.inv});
                chk("ev_invalid", {31'd0, bus.invalid_pattern}, {31'd0, e.inv});
                chk("ev_seqerr",  {31'd0, bus.seq_error}, {31'd0, e.seq});
                chk("ev_pvalid",  {31'd0, bus.period_valid}, {31'd0, e.pv});
                chk("ev_digit",   {28'd0, bus.digit}, {28'd0, e.digit});
                chk("ev_locked",  {31'd0, bus.locked}, {31'd0, e.locked});
                chk("ev_errcnt",  {24'd0, bus.error_count}, {24'd0, e.errs});
                if (e.pv) chk("ev_period", {8'd0, bus.period}, e.per);
                chk("ev8_pulses", {28'd0, bus8.digit_valid, bus8.invalid_pattern, bus8.seq_error, bus8.period_valid},
                                  {28'd0, ~e.inv, e.inv, e.seq, e.pv});
                if (e.pv) chk("ev8_period", {24'd0, bus8.period}, (e.per > 255) ? 255 : e.per);
                $display("event cyc=%0d digit=%0h inv=%0b seq=%0b pv=%0b period=%0d/%0d locked=%0b errs=%0d",
                         cyc, bus.digit, bus.invalid_pattern, bus.seq_error, bus.period_valid,
                         bus.period, bus8.period, bus.locked, bus.error_count);
            end
        end
    end

    initial begin
        bus.segments_in  = 7'b0000000;
        bus8.segments_in = 7'b0000000;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;

        // Blank bus after reset matches the accepted pattern: silent.
        apply(7'b0000000, 20);

        // First digit locks without period or sequence check.
        apply(seg(0), 100);
        chk("t1_locked", {31'd0, bus.locked}, 32'd1);

        // Full count with wrap 9 -> 0.
        for (int d = 1; d <= 9; d++) apply(seg(d), 100);
        apply(seg(0), 100);
        chk("t2_errcnt", {24'd0, bus.error_count}, 32'd0);

        // Short glitch between identical digits.
        apply(seg(1), 100);
        apply(seg(2), 100);
        apply(7'b0000110, 3);
        apply(seg(2), 50);
        chk("t3_digit", {28'd0, bus.digit}, 32'd2);

        // Skipped digit.
        apply(seg(3), 50);
        apply(seg(5), 50);
        chk("t4_locked", {31'd0, bus.locked}, 32'd1);

        // Invalid pattern unlocks, digit held; relock without sequence check.
        apply(seg(4), 50);
        apply(7'b1010101, 50);
        chk("t5_unlocked", {31'd0, bus.locked}, 32'd0);
        chk("t5_digit",    {28'd0, bus.digit}, 32'd4);
        apply(seg(7), 50);
        chk("t5_relocked", {31'd0, bus.locked}, 32'd1);

        // Long hold: 8-bit period saturates, 24-bit one does not.
        apply(seg(1), 300);
        apply(seg(2), 50);

        // Reset while a new candidate is only partly stable.
        @(negedge clk);
        bus.segments_in  = seg(3);
        bus8.segments_in = seg(3);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("midreset");
        reset = 1'b0;
        bus.segments_in  = 7'b0000000;
        bus8.segments_in = 7'b0000000;
        m_acc = 7'b0000000; m_locked = 1'b0; m_digit = 0; m_errs = 0;
        apply(7'b0000000, 10);
        chk("t6_quiet", {31'd0, bus.digit_valid}, 32'd0);

        // Out-of-range digits relative to MODULUS.
        apply(seg(0), 20);
        apply(seg(9), 20);
        apply(seg(10), 20);
        apply(seg(11), 20);

        // Enough sequence errors to saturate the error counter.
        for (int i = 0; i < 130; i++) begin
            apply(seg(3), 6);
            apply(seg(5), 6);
        end
        repeat (20) @(negedge clk);
        chk("sat_errcnt", {24'd0, bus.error_count}, 32'd255);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
